// File: rtl/ascon_state_reg_v2.sv
// Ascon state register: init load, permutation capture, key XOR and
// rate-block absorb with a registered output block and ready/valid handshake.
module ascon_state_reg_v2 #(
  parameter int unsigned NUM_WORDS  = 5,
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned RATE_WORDS = 2,
  parameter int unsigned KEY_WORDS  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_init,
  input  logic [NUM_WORDS*WORD_W-1:0]        init_value,
  input  logic [NUM_WORDS*WORD_W-1:0]        perm_out,
  input  logic                               perm_valid,
  input  logic                               perm_busy,
  input  logic                               key_xor_en,
  input  logic                               key_xor_sel,
  input  logic [KEY_WORDS*WORD_W-1:0]        key,
  input  logic                               absorb_valid,
  output logic                               absorb_ready,
  input  logic [RATE_WORDS*WORD_W-1:0]       absorb_data,
  input  logic [RATE_WORDS*WORD_W/8-1:0]     absorb_bmask,
  input  logic                               absorb_replace,
  output logic [RATE_WORDS*WORD_W-1:0]       dout,
  output logic                               dout_valid,
  input  logic                               dout_ready,
  output logic [15:0]                        block_cnt,
  output logic [NUM_WORDS*WORD_W-1:0]        state
);

  localparam int unsigned SW = NUM_WORDS * WORD_W;
  localparam int unsigned RW = RATE_WORDS * WORD_W;
  localparam int unsigned NB = RW / 8;
  // Shift that moves the key from the last words up to word RATE_WORDS.
  localparam int unsigned KEY_SH1 = (NUM_WORDS - RATE_WORDS - KEY_WORDS) * WORD_W;

  logic [RW-1:0] mask;
  logic [RW-1:0] rate_old;
  logic [RW-1:0] rate_new;
  logic [RW-1:0] dout_new;
  logic [SW-1:0] key_vec;
  logic          transfer;

  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      mask[8*b +: 8] = {8{absorb_bmask[b]}};
    end
  end

  assign rate_old = state[SW-1 -: RW];
  assign rate_new = absorb_replace ? ((absorb_data & mask) | (rate_old & ~mask))
                                   : (rate_old ^ (absorb_data & mask));
  assign dout_new = (rate_old ^ absorb_data) & mask;
  assign key_vec  = SW'(key) << (key_xor_sel ? KEY_SH1 : 0);

  assign absorb_ready = !perm_busy && !load_init && !perm_valid && !key_xor_en &&
                        (!dout_valid || dout_ready);
  assign transfer     = absorb_valid && absorb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      block_cnt  <= '0;
    end else begin
      if (load_init) begin
        state     <= init_value;
        block_cnt <= '0;
      end else if (perm_valid) begin
        state <= perm_out;
      end else if (key_xor_en) begin
        state <= state ^ key_vec;
      end else if (transfer) begin
        state[SW-1 -: RW] <= rate_new;
        block_cnt         <= block_cnt + 16'd1;
      end

      // A new transfer reloads the output even while the old block is consumed.
      if (transfer) begin
        dout       <= dout_new;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
